seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/div_pkg.sv | 21 ++
 rtl/cla_adder8.sv | 33 +++
 rtl/div_step.sv | 51 +++++
 rtl/seq_divider.sv | 135 +++++++++++++
 tb/tb_seq_divider.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared constants and types for the sequential signed divider.
//   DIV_WIDTH   : default operand/result width
//   div_state_e : controller state encoding (idle, iterate, publish result)
//   cnt_width() : step-counter width needed for a given operand width
package div_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } div_state_e;

    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned DIV_CNT_W = cnt_width(DIV_WIDTH);

endpackage

// File: rtl/cla_adder8.sv
// 8-bit carry-lookahead adder block, cascaded by wider arithmetic.
//   a_i, b_i : addends
//   ci_i     : carry in
//   s_o      : sum
//   co_o     : carry out
module cla_adder8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       ci_i,
    output logic [7:0] s_o,
    output logic       co_o
);

    logic [7:0] prop;
    logic [7:0] gen;
    logic [8:0] carry;

    assign prop = a_i ^ b_i;
    assign gen  = a_i & b_i;

    // Carries come straight from generate/propagate terms; synthesis flattens this
    // into the two-level lookahead form.
    always_comb begin
        carry[0] = ci_i;
        for (int i = 0; i < 8; i++) begin
            carry[i+1] = gen[i] | (prop[i] & carry[i]);
        end
    end

    assign s_o  = prop ^ carry[7:0];
    assign co_o = carry[8];

endmodule

// File: rtl/div_step.sv
// One restoring-division step: conditionally subtract the divisor magnitude from
// the already-shifted partial remainder.
//   rem_i  : shifted partial remainder, W+1 bits
//   dmag_i : divisor magnitude
//   rem_o  : next partial remainder
//   q_o    : quotient bit (1 when rem_i >= dmag_i)
module div_step #(
    parameter int unsigned W = 32
) (
    input  logic [W:0]   rem_i,
    input  logic [W-1:0] dmag_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    localparam int unsigned NBlk = (W + 1 + 7) / 8;
    localparam int unsigned PW   = NBlk * 8;

    logic [PW-1:0] a_ext;
    logic [PW-1:0] b_inv;
    logic [PW-1:0] diff;

    assign a_ext = PW'(rem_i);
    assign b_inv = ~PW'(dmag_i);

    // a + ~b + 1 over zero-extended operands; final carry-out is "no borrow".
    for (genvar k = 0; k < NBlk; k++) begin : g_blk
        logic ci;
        logic co;
        if (k == 0) begin : g_first
            assign ci = 1'b1;
        end else begin : g_next
            assign ci = g_blk[k-1].co;
        end
        cla_adder8 u_add (
            .a_i  (a_ext[8*k +: 8]),
            .b_i  (b_inv[8*k +: 8]),
            .ci_i (ci),
            .s_o  (diff[8*k +: 8]),
            .co_o (co)
        );
    end

    assign q_o   = g_blk[NBlk-1].co;
    assign rem_o = q_o ? diff[W-1:0] : rem_i[W-1:0];

    // A successful trial is always below the divisor, so the top bits are zero.
    logic unused_diff_hi;
    assign unused_diff_hi = ^diff[PW-1:W];

endmodule

// File: rtl/seq_divider.sv
// Sequential signed divider, one restoring step per clock.
//   clock, reset     : rising-edge clock, synchronous active-high reset
//   ctrl_DIV         : start pulse; operands captured on that edge (restarts any run)
//   data_operandA/B  : signed dividend / divisor
//   data_result      : signed quotient (truncated toward zero)
//   data_remainder   : signed remainder (sign follows dividend)
//   data_exception   : divide-by-zero flag, valid with data_resultRDY
//   data_resultRDY   : one-cycle pulse marking a valid result
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY
);

    localparam int unsigned CntW = cnt_width(WIDTH);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dmag_q, dmag_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             dzero_q, dzero_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;

    // The dividend magnitude is shifted out of quo_q's MSB into the remainder.
    div_step #(
        .W (WIDTH)
    ) u_step (
        .rem_i  ({rem_q, quo_q[WIDTH-1]}),
        .dmag_i (dmag_q),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dmag_d      = dmag_q;
        negq_d      = negq_q;
        negr_d      = negr_q;
        dzero_d     = dzero_q;
        result_d    = result_q;
        remainder_d = remainder_q;
        exc_d       = exc_q;
        rdy_d       = 1'b0;

        if (ctrl_DIV) begin
            // Capture wins in every state, so an in-flight division never reports.
            negq_d  = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            negr_d  = data_operandA[WIDTH-1];
            dzero_d = (data_operandB == '0);
            quo_d   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
            dmag_d  = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
            rem_d   = '0;
            cnt_d   = '0;
            state_d = StRun;
        end else begin
            unique case (state_q)
                StIdle: ;
                StRun: begin
                    rem_d = step_rem;
                    quo_d = {quo_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        state_d = StDone;
                    end
                end
                StDone: begin
                    rdy_d       = 1'b1;
                    exc_d       = dzero_q;
                    result_d    = dzero_q ? '0 : (negq_q ? -quo_q : quo_q);
                    remainder_d = dzero_q ? '0 : (negr_q ? -rem_q : rem_q);
                    state_d     = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dmag_q      <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            dzero_q     <= 1'b0;
            result_q    <= '0;
            remainder_q <= '0;
            exc_q       <= 1'b0;
            rdy_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dmag_q      <= dmag_d;
            negq_q      <= negq_d;
            negr_q      <= negr_d;
            dzero_q     <= dzero_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
            exc_q       <= exc_d;
            rdy_q       <= rdy_d;
        end
    end

    assign data_result    = result_q;
    assign data_remainder = remainder_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

    localparam int W = 32;

    logic          clk;
    logic          reset;
    logic          ctrl_div;
    logic [W-1:0]  op_a;
    logic [W-1:0]  op_b;
    logic [W-1:0]  result;
    logic [W-1:0]  remainder;
    logic          exc;
    logic          rdy;

    int n_cmp = 0;
    int n_err = 0;

    seq_divider #(
        .WIDTH (W)
    ) dut (
        .clock          (clk),
        .reset          (reset),
        .ctrl_DIV       (ctrl_div),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (result),
        .data_remainder (remainder),
        .data_exception (exc),
        .data_resultRDY (rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain 64-bit signed arithmetic, truncated back to W bits.
    task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic [W-1:0] q, output logic [W-1:0] r, output logic e);
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = '0;
            r = '0;
            e = 1'b1;
        end else begin
            q = W'(sa / sb);
            r = W'(sa % sb);
            e = 1'b0;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the capture edge, with the
    // operand bus scrambled to show it is ignored during the run.
    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        ctrl_div = 1'b1;
        op_a     = a;
        op_b     = b;
        @(posedge clk);
        #1;
        ctrl_div = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic run_and_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         ee;
        int           lat;
        ref_div(a, b, eq, er, ee);
        start(a, b);
        lat = 0;
        for (int i = 1; i <= W + 8; i++) begin
            @(posedge clk);
            #1;
            if (rdy) begin
                lat = i;
                break;
            end
        end
        check_eq({tag, ":latency"}, 64'(lat), 64'(W + 1));
        check_eq({tag, ":result"}, 64'(result), 64'(eq));
        check_eq({tag, ":remainder"}, 64'(remainder), 64'(er));
        check_eq({tag, ":exception"}, 64'(exc), 64'(ee));
        @(posedge clk);
        #1;
        check_eq({tag, ":rdy_pulse"}, 64'(rdy), 64'(0));
        check_eq({tag, ":held"}, 64'(result), 64'(eq));
    endtask

    initial begin
        int rdy_cnt;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset    = 1'b1;
        ctrl_div = 1'b0;
        op_a     = '0;
        op_b     = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset:result", 64'(result), 64'(0));
        check_eq("reset:remainder", 64'(remainder), 64'(0));
        check_eq("reset:exception", 64'(exc), 64'(0));
        check_eq("reset:rdy", 64'(rdy), 64'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        run_and_check("100/7", 32'd100, 32'd7);
        run_and_check("-100/7", -32'sd100, 32'd7);
        run_and_check("100/-7", 32'd100, -32'sd7);
        run_and_check("5/0", 32'd5, 32'd0);
        run_and_check("min/-1", 32'h8000_0000, 32'hFFFF_FFFF);
        run_and_check("0/3", 32'd0, 32'd3);

        // Restart mid-run: only the second division may report.
        start(32'd100, 32'd7);
        rdy_cnt = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (rdy) rdy_cnt++;
        end
        check_eq("restart:no_early_rdy", 64'(rdy_cnt), 64'(0));
        run_and_check("restart:9/2", 32'd9, 32'd2);
        rdy_cnt = 0;
        repeat (W + 4) begin
            @(posedge clk);
            #1;
            if (rdy) rdy_cnt++;
        end
        check_eq("restart:no_late_rdy", 64'(rdy_cnt), 64'(0));

        // Reset on the 20th edge of a division abandons it.
        start(32'd123456, 32'd789);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        ctrl_div = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ctrl_div = 1'b0;
        check_eq("abort:result", 64'(result), 64'(0));
        check_eq("abort:remainder", 64'(remainder), 64'(0));
        check_eq("abort:exception", 64'(exc), 64'(0));
        rdy_cnt = 0;
        repeat (W + 8) begin
            @(posedge clk);
            #1;
            if (rdy) rdy_cnt++;
        end
        check_eq("abort:no_rdy", 64'(rdy_cnt), 64'(0));
        check_eq("abort:result_idle", 64'(result), 64'(0));
        run_and_check("abort:6/3", 32'd6, 32'd3);

        for (int n = 0; n < 150; n++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = W'($urandom_range(1, 15));
                2: rb = -W'($urandom_range(1, 15));
                3: ra = 32'h8000_0000;
                4: rb = rb >> $urandom_range(0, 31);
                5: ra = ra >> $urandom_range(0, 31);
                default: ;
            endcase
            run_and_check($sformatf("rand%0d", n), ra, rb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
